id_ex_pipe_ctrl: RTL and testbench
==================================

Name: id_ex_pipe_ctrl

Overview:
- Consumer end of the hazard controls (forwardA/B, stall, flush).
- Owns the ID/EX pipeline register and applies the hazard controls to it: holds the front end, inserts bubbles, squashes on mispredict, and muxes forwarded operands into EX.
- Sits between decode and EX. Feeds id_ex_rs1/rs2 back to the hazard detection unit.
- Also keeps stall/flush performance counters and a stall watchdog.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, decoded control bundle width; bit0 reg_write, bit1 mem_read, bit2 mem_write, bit3 branch, others opaque.
- FLUSH_CYCLES, 1, squash window length after a flush (1..7).
- MAX_STALL, 15, consecutive stall cycles before the watchdog fires.
- CNT_W, 16, performance counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_pc  in  XLEN  decode PC
- id_rs1, id_rs2, id_rd  in  5 each  decode register indices
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- hazard_forwardA, hazard_forwardB  in  2  forward selects for the instruction now in ID/EX
- hazard_stall  in  1  load-use stall request
- hazard_flush  in  1  mispredict flush request
- ex_mem_fwd_data  in  XLEN  EX/MEM result
- mem_wb_fwd_data  in  XLEN  MEM/WB write data
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear
- id_ex_rs1, id_ex_rs2  out  5 each  registered source indices
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm  out  XLEN  registered
- ex_rd  out  5  registered
- ex_ctrl  out  CTRL_W  registered control bundle
- ex_op_a, ex_op_b  out  XLEN  forwarded operands
- stall_cnt, flush_cnt  out  CNT_W  bubble counters
- stall_timeout  out  1  sticky watchdog error

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values:
  - All ID/EX registers 0, ex_valid=0, ex_ctrl=0.
  - state=RUN, squash counter 0, stall run counter 0.
  - stall_cnt=0, flush_cnt=0, stall_timeout=0.
  - Combinational outputs after reset: pc_en=1, if_id_en=1, if_id_flush=0.
- FSM states: RUN, STALL, FLUSH.
  - flush_act = hazard_flush OR state==FLUSH.
  - stall_act = hazard_stall AND NOT flush_act. Flush always beats stall.
- Transitions:
  - RUN→FLUSH on hazard_flush; load squash counter with FLUSH_CYCLES-1.
  - RUN→STALL on stall_act.
  - STALL→RUN when hazard_stall=0.
  - STALL→FLUSH on hazard_flush.
  - FLUSH: hazard_flush reloads the counter. Otherwise decrement; at 0 go to RUN. hazard_stall is ignored while in FLUSH.
- Combinational controls:
  - pc_en = NOT stall_act.
  - if_id_en = NOT stall_act.
  - if_id_flush = flush_act.
- ID/EX register update every cycle:
  - flush_act or stall_act: load a bubble (ex_valid=0, ex_ctrl=0, rd/rs1/rs2=0; pc, imm and data don't-care, hold allowed).
  - Otherwise load the decode fields; ex_valid=id_valid; ctrl forced to 0 when id_valid=0.
- Operand muxes (combinational), select 00→registered rs data, 10→ex_mem_fwd_data, 01→mem_wb_fwd_data, 11→registered rs data (reserved). Applied independently for A and B.
- Counters: saturating at all-ones, no wrap.
  - stall_cnt +1 per cycle with stall_act.
  - flush_cnt +1 per cycle with flush_act.
- Watchdog:
  - Stall run counter increments while stall_act and clears otherwise.
  - When it reaches MAX_STALL, set stall_timeout. It stays set until reset.
- Reset mid-stall or mid-flush: immediate return to reset values, with no residual squash.

Decomposition:
- Shared package pipe_pkg holds:
  - Control-bundle bit positions (CTRL_REGWRITE=0, CTRL_MEMREAD=1, CTRL_MEMWRITE=2, CTRL_BRANCH=3).
  - Forward select encodings FWD_REG=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10.
  - FSM state enum.
- One natural sub-module: fwd_mux, one XLEN 4:1 operand select, instantiated twice.

Test Plan:
- Reset then id_valid=1, id_pc=0x100, no hazards → next cycle ex_valid=1, ex_pc=0x100; pc_en=if_id_en=1 throughout.
- hazard_stall=1 for 2 cycles → pc_en=if_id_en=0 for both cycles; ex_valid=0, ex_ctrl=0 after each; stall_cnt=2. Stall drops → decode instruction loads.
- hazard_flush=1 together with hazard_stall=1, FLUSH_CYCLES=2 → pc_en=1, if_id_flush=1 for 2 cycles, 2 bubbles, flush_cnt=2, stall_cnt=0.
- Registered rs1_data=0x11, ex_mem_fwd_data=0x22, mem_wb_fwd_data=0x33 → forwardA 00/10/01/11 gives ex_op_a 0x11/0x22/0x33/0x11; B checked the same way.
- hazard_stall held 15 cycles (MAX_STALL=15) → stall_timeout=1 after the 15th cycle and stays 1 after the stall clears. Assert reset_n=0 mid-stall → stall_timeout, counters and ex_valid all 0 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle bits,
// forward select codes and ID/EX control FSM states.
package pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_BRANCH   = 3;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } pipe_state_e;

endpackage

// File: rtl/fwd_mux.sv
// One EX operand select: register data or a
// forwarded result from EX/MEM or MEM/WB.
module fwd_mux
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel_i,
  input  logic [XLEN-1:0] reg_i,
  input  logic [XLEN-1:0] ex_mem_i,
  input  logic [XLEN-1:0] mem_wb_i,
  output logic [XLEN-1:0] op_o
);

  always_comb begin
    op_o = reg_i;
    unique case (1'b1)
      (sel_i == FWD_EX_MEM): op_o = ex_mem_i;
      (sel_i == FWD_MEM_WB): op_o = mem_wb_i;
      default:               op_o = reg_i;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe_ctrl.sv
// ID/EX pipeline register with stall/flush control,
// operand forwarding, bubble counters and stall watchdog.
module id_ex_pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int CTRL_W       = 8,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 15,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [1:0]        hazard_forwardA,
  input  logic [1:0]        hazard_forwardB,
  input  logic              hazard_stall,
  input  logic              hazard_flush,
  input  logic [XLEN-1:0]   ex_mem_fwd_data,
  input  logic [XLEN-1:0]   mem_wb_fwd_data,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic [4:0]        id_ex_rs1,
  output logic [4:0]        id_ex_rs2,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              stall_timeout
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [2:0] SQ_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic MULTI = (FLUSH_CYCLES > 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);
  localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(MAX_STALL - 1);

  pipe_state_e       state_q;
  logic [2:0]        sq_q;
  logic [RUN_W-1:0]  run_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;
  logic              timeout_q;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   imm_q;
  logic [XLEN-1:0]   d1_q;
  logic [XLEN-1:0]   d2_q;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  logic [4:0]        rd_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic flush_act;
  logic stall_act;
  logic bubble;

  assign flush_act = hazard_flush | (state_q == ST_FLUSH);
  assign stall_act = hazard_stall & ~flush_act;
  assign bubble    = flush_act | stall_act;

  assign pc_en       = ~stall_act;
  assign if_id_en    = ~stall_act;
  assign if_id_flush = flush_act;

  // The request cycle is the first squash cycle, so a
  // one-cycle window never needs the FLUSH state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      sq_q    <= '0;
    end else begin
      unique case (state_q)
        ST_RUN, ST_STALL: begin
          if (hazard_flush) begin
            state_q <= MULTI ? ST_FLUSH : ST_RUN;
            sq_q    <= SQ_INIT;
          end else if (stall_act) begin
            state_q <= ST_STALL;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (hazard_flush) begin
            state_q <= MULTI ? ST_FLUSH : ST_RUN;
            sq_q    <= SQ_INIT;
          end else if (sq_q <= 3'd1) begin
            state_q <= ST_RUN;
            sq_q    <= '0;
          end else begin
            sq_q    <= sq_q - 3'd1;
          end
        end
        default: begin
          state_q <= ST_RUN;
          sq_q    <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_act) begin
        if (run_q != RUN_MAX) run_q <= run_q + 1'b1;
        if (run_q >= RUN_PRE) timeout_q <= 1'b1;
      end else begin
        run_q <= '0;
      end
      if (stall_act && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_act && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (bubble) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= id_valid;
      pc_q    <= id_pc;
      imm_q   <= id_imm;
      d1_q    <= id_rs1_data;
      d2_q    <= id_rs2_data;
      rs1_q   <= id_rs1;
      rs2_q   <= id_rs2;
      rd_q    <= id_rd;
      ctrl_q  <= id_valid ? id_ctrl : '0;
    end
  end

  fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .sel_i    (hazard_forwardA),
    .reg_i    (d1_q),
    .ex_mem_i (ex_mem_fwd_data),
    .mem_wb_i (mem_wb_fwd_data),
    .op_o     (ex_op_a)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .sel_i    (hazard_forwardB),
    .reg_i    (d2_q),
    .ex_mem_i (ex_mem_fwd_data),
    .mem_wb_i (mem_wb_fwd_data),
    .op_o     (ex_op_b)
  );

  assign id_ex_rs1     = rs1_q;
  assign id_ex_rs2     = rs2_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_imm        = imm_q;
  assign ex_rd         = rd_q;
  assign ex_ctrl       = ctrl_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// Randomized bench for id_ex_pipe_ctrl against a
// cycle-level behavioural model of the pipeline rules.
module tb_id_ex_pipe_ctrl;

  localparam int XLEN = 32;
  localparam int CW   = 8;
  localparam int FC   = 2;
  localparam int MS   = 15;
  localparam int CNTW = 5;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [XLEN-1:0] id_pc = '0;
  logic [4:0]      id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [XLEN-1:0] id_rs1_data = '0, id_rs2_data = '0;
  logic [XLEN-1:0] id_imm = '0;
  logic [CW-1:0]   id_ctrl = '0;
  logic [1:0]      fwd_a = '0, fwd_b = '0;
  logic            hz_stall = 1'b0, hz_flush = 1'b0;
  logic [XLEN-1:0] exm = '0, mwb = '0;

  logic            pc_en, if_id_en, if_id_flush;
  logic [4:0]      id_ex_rs1, id_ex_rs2, ex_rd;
  logic            ex_valid, stall_timeout;
  logic [XLEN-1:0] ex_pc, ex_imm, ex_op_a, ex_op_b;
  logic [CW-1:0]   ex_ctrl;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  int unsigned m_rem, m_scnt, m_fcnt, m_run;
  bit          m_to, m_valid;
  logic [XLEN-1:0] m_pc, m_imm, m_d1, m_d2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [CW-1:0] m_ctrl;

  always #5 clk = ~clk;

  id_ex_pipe_ctrl #(
    .XLEN(XLEN), .CTRL_W(CW), .FLUSH_CYCLES(FC),
    .MAX_STALL(MS), .CNT_W(CNTW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rd           (id_rd),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_ctrl         (id_ctrl),
    .hazard_forwardA (fwd_a),
    .hazard_forwardB (fwd_b),
    .hazard_stall    (hz_stall),
    .hazard_flush    (hz_flush),
    .ex_mem_fwd_data (exm),
    .mem_wb_fwd_data (mwb),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .if_id_flush     (if_id_flush),
    .id_ex_rs1       (id_ex_rs1),
    .id_ex_rs2       (id_ex_rs2),
    .ex_valid        (ex_valid),
    .ex_pc           (ex_pc),
    .ex_imm          (ex_imm),
    .ex_rd           (ex_rd),
    .ex_ctrl         (ex_ctrl),
    .ex_op_a         (ex_op_a),
    .ex_op_b         (ex_op_b),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .stall_timeout   (stall_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(
    input logic [1:0] s, input logic [XLEN-1:0] r);
    if (s == 2'b10) return exm;
    if (s == 2'b01) return mwb;
    return r;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_scnt = 0; m_fcnt = 0; m_run = 0;
    m_to = 0; m_valid = 0;
    m_pc = '0; m_imm = '0; m_d1 = '0; m_d2 = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0;
  endtask

  task automatic chk_regs();
    chk("ex_valid", ex_valid, m_valid);
    chk("ex_ctrl", ex_ctrl, m_ctrl);
    chk("ex_rd", ex_rd, m_rd);
    chk("id_ex_rs1", id_ex_rs1, m_rs1);
    chk("id_ex_rs2", id_ex_rs2, m_rs2);
    chk("stall_cnt", stall_cnt, m_scnt);
    chk("flush_cnt", flush_cnt, m_fcnt);
    chk("stall_timeout", stall_timeout, m_to);
    if (m_valid) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_imm", ex_imm, m_imm);
    end
  endtask

  // Inputs are already driven; check, clock, update, check.
  task automatic step();
    bit fa, sa;
    #1;
    fa = hz_flush || (m_rem != 0);
    sa = hz_stall && !fa;
    chk("pc_en", pc_en, !sa);
    chk("if_id_en", if_id_en, !sa);
    chk("if_id_flush", if_id_flush, fa);
    if (m_valid) begin
      chk("ex_op_a", ex_op_a, pick(fwd_a, m_d1));
      chk("ex_op_b", ex_op_b, pick(fwd_b, m_d2));
    end
    @(posedge clk);
    if (hz_flush) m_rem = FC - 1;
    else if (m_rem != 0) m_rem--;
    if (fa || sa) begin
      m_valid = 0; m_ctrl = '0;
      m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_imm = id_imm;
      m_d1 = id_rs1_data; m_d2 = id_rs2_data;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_ctrl = id_valid ? id_ctrl : '0;
    end
    if (sa && m_scnt < CMAX) m_scnt++;
    if (fa && m_fcnt < CMAX) m_fcnt++;
    m_run = sa ? m_run + 1 : 0;
    if (m_run >= MS) m_to = 1;
    #1;
    chk_regs();
  endtask

  task automatic rand_instr();
    id_valid    = ($urandom_range(0, 7) != 0);
    id_pc       = $urandom & 32'hffff_fffc;
    id_rs1      = 5'($urandom);
    id_rs2      = 5'($urandom);
    id_rd       = 5'($urandom);
    id_rs1_data = $urandom;
    id_rs2_data = $urandom;
    id_imm      = $urandom;
    id_ctrl     = 8'($urandom);
    fwd_a       = 2'($urandom);
    fwd_b       = 2'($urandom);
    exm         = $urandom;
    mwb         = $urandom;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_regs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #3;
    chk_regs();
    chk("rst_pc_en", pc_en, 1);
    chk("rst_if_id_en", if_id_en, 1);
    chk("rst_if_id_flush", if_id_flush, 0);
    do_reset();

    id_valid = 1; id_pc = 32'h100; id_ctrl = 8'h05;
    id_rd = 5'd3; id_rs1 = 5'd1; id_rs2 = 5'd2;
    step();
    chk("first_valid", ex_valid, 1);
    chk("first_pc", ex_pc, 32'h100);

    hz_stall = 1; id_pc = 32'h104;
    step();
    chk("stall1_ctrl", ex_ctrl, 0);
    step();
    chk("stall2_valid", ex_valid, 0);
    chk("stall2_cnt", stall_cnt, 2);
    hz_stall = 0;
    step();
    chk("after_stall_pc", ex_pc, 32'h104);

    do_reset();
    hz_flush = 1; hz_stall = 1;
    step();
    hz_flush = 0;
    step();
    hz_stall = 0;
    chk("flush_cnt2", flush_cnt, 2);
    chk("flush_stall0", stall_cnt, 0);
    step();
    chk("post_flush_valid", ex_valid, 1);

    id_valid = 1; id_rs1_data = 32'h11; id_rs2_data = 32'h44;
    exm = 32'h22; mwb = 32'h33; fwd_a = 0; fwd_b = 0;
    step();
    for (int s = 0; s < 4; s++) begin
      fwd_a = 2'(s); fwd_b = 2'(3 - s);
      step();
    end

    do_reset();
    hz_stall = 1;
    for (int c = 1; c <= MS; c++) begin
      step();
      if (c == MS - 1) chk("wd_early", stall_timeout, 0);
    end
    chk("wd_fire", stall_timeout, 1);
    hz_stall = 0;
    step();
    chk("wd_sticky", stall_timeout, 1);
    hz_stall = 1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_to", stall_timeout, 0);
    chk("arst_scnt", stall_cnt, 0);
    chk("arst_valid", ex_valid, 0);
    hz_stall = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 1500; i++) begin
      rand_instr();
      hz_stall = ($urandom_range(0, 99) < 30);
      hz_flush = ($urandom_range(0, 99) < 8);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "bench time limit");
  end

endmodule
